// File: rtl/button_pulse_generator_pkg.sv
// rtl/button_pulse_generator_pkg.sv - shared types and defaults for button input conditioning
package button_pulse_generator_pkg;

  // Per-channel debounce state encoding
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } db_state_e;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/button_pulse_generator_debounce_channel.sv
// rtl/button_pulse_generator_debounce_channel.sv - one button: synchronizer, debounce FSM, pulses, press counter
module debounce_channel
  import button_pulse_generator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       button_ni,
  output logic       level_o,
  output logic       press_pulse_o,
  output logic       release_pulse_o,
  output logic [3:0] press_count_o
);

  // Last counter value before a level change is accepted
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync1_q, sync2_q;
  db_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic [3:0]           count_q, count_d;
  logic                 s;

  // Synchronizer flops hold the raw active-low value; s is 1 when pressed
  assign s = ~sync2_q;

  // State register; synchronizer resets to released so a held button reads as a new press
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 4'd0;
    end else begin
      sync1_q   <= button_ni;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  // Debounce next-state: a change must hold DEBOUNCE_CYCLES synchronized cycles
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = count_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o         = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign press_count_o   = count_q;

endmodule

// File: rtl/button_pulse_generator.sv
// rtl/button_pulse_generator.sv - WIDTH independent debounced button channels
module button_pulse_generator
  import button_pulse_generator_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   button_n,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   press_pulse,
  output logic [WIDTH-1:0]   release_pulse,
  output logic [4*WIDTH-1:0] press_count
);

  // One fully independent channel per button; counters packed 4 bits per channel
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_ch (
      .clock_i        (clock),
      .reset_ni       (reset),
      .button_ni      (button_n[i]),
      .level_o        (level[i]),
      .press_pulse_o  (press_pulse[i]),
      .release_pulse_o(release_pulse[i]),
      .press_count_o  (press_count[4*i +: 4])
    );
  end

endmodule

// File: tb/tb_button_pulse_generator.sv
// tb/tb_button_pulse_generator.sv - scoreboard bench for button_pulse_generator
module tb_button_pulse_generator;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] button_n;
  logic [1:0] level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [7:0] press_count;

  typedef struct {
    int         edge_n;
    logic [1:0] press;
    logic [1:0] rel;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   press_seen = 0;
  int   release_seen = 0;
  logic [3:0] model_cnt [2];

  button_pulse_generator #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button_n     (button_n),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt = edge_cnt + 1;

  // Any pulse must match the oldest scoreboard entry: edge, both pulse vectors, counters
  always @(negedge clock) begin
    if (press_pulse != 2'b00 || release_pulse != 2'b00) begin
      for (int b = 0; b < 2; b++) begin
        if (press_pulse[b])   press_seen   = press_seen + 1;
        if (release_pulse[b]) release_seen = release_seen + 1;
      end
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse edge=%0d press=%b release=%b", edge_cnt, press_pulse, release_pulse);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (edge_cnt !== e.edge_n) begin
          errors = errors + 1;
          $display("FAIL pulse_edge got=%0d exp=%0d", edge_cnt, e.edge_n);
        end
        checks = checks + 1;
        if (press_pulse !== e.press) begin
          errors = errors + 1;
          $display("FAIL press_pulse got=%b exp=%b", press_pulse, e.press);
        end
        checks = checks + 1;
        if (release_pulse !== e.rel) begin
          errors = errors + 1;
          $display("FAIL release_pulse got=%b exp=%b", release_pulse, e.rel);
        end
        checks = checks + 1;
        if (press_count !== e.cnt) begin
          errors = errors + 1;
          $display("FAIL press_count got=%h exp=%h", press_count, e.cnt);
        end
      end
    end
  end

  // Change is first sampled at the next rising edge; pulse appears after edge k+1+D
  task automatic push_exp(input logic [1:0] p, input logic [1:0] r);
    exp_t e;
    e.edge_n = edge_cnt + 1 + 1 + D;
    e.press  = p;
    e.rel    = r;
    e.cnt    = {model_cnt[1], model_cnt[0]};
    sb.push_back(e);
  endtask

  task automatic press_ch(input logic [1:0] mask);
    button_n = button_n & ~mask;
    for (int b = 0; b < 2; b++) if (mask[b]) model_cnt[b] = model_cnt[b] + 4'd1;
    push_exp(mask, 2'b00);
  endtask

  task automatic release_ch(input logic [1:0] mask);
    button_n = button_n | mask;
    push_exp(2'b00, mask);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    button_n  = 2'b11;
    model_cnt[0] = 4'd0;
    model_cnt[1] = 4'd0;
    wait_cycles(3);
    checks = checks + 1;
    if (level !== 2'b00 || press_pulse !== 2'b00 || release_pulse !== 2'b00 || press_count !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL reset_state got level=%b pp=%b rp=%b cnt=%h exp all zero", level, press_pulse, release_pulse, press_count);
    end
    reset = 1'b1;
    wait_cycles(3);
  endtask

  task automatic test_drained(input string name);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s missing_pulses got=%0d pending exp=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_level(input string name, input logic [1:0] exp);
    checks = checks + 1;
    if (level !== exp) begin
      errors = errors + 1;
      $display("FAIL %s level got=%b exp=%b", name, level, exp);
    end
  endtask

  task automatic test_clean_press;
    press_ch(2'b01);
    wait_cycles(20);
    test_drained("clean_press");
    check_level("clean_press", 2'b01);
  endtask

  task automatic test_release;
    release_ch(2'b01);
    wait_cycles(12);
    test_drained("release");
    check_level("release", 2'b00);
  endtask

  task automatic test_bounce;
    button_n[0] = 1'b0;
    wait_cycles(2);
    button_n[0] = 1'b1;
    wait_cycles(1);
    press_ch(2'b01);
    wait_cycles(12);
    test_drained("bounce_press");
    check_level("bounce_press", 2'b01);
    release_ch(2'b01);
    wait_cycles(12);
    test_drained("bounce_release");
  endtask

  task automatic test_simultaneous;
    press_ch(2'b11);
    wait_cycles(12);
    test_drained("simul_press");
    check_level("simul_press", 2'b11);
    release_ch(2'b11);
    wait_cycles(12);
    test_drained("simul_release");
    check_level("simul_release", 2'b00);
  endtask

  task automatic test_reset_mid;
    button_n[0] = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    model_cnt[0] = 4'd0;
    model_cnt[1] = 4'd0;
    checks = checks + 1;
    if (level !== 2'b00 || press_pulse !== 2'b00 || release_pulse !== 2'b00 || press_count !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL reset_mid got level=%b pp=%b rp=%b cnt=%h exp all zero", level, press_pulse, release_pulse, press_count);
    end
    test_drained("reset_mid");
    reset = 1'b1;
    model_cnt[0] = 4'd1;
    push_exp(2'b01, 2'b00);
    wait_cycles(12);
    test_drained("held_through_reset");
    check_level("held_through_reset", 2'b01);
    release_ch(2'b01);
    wait_cycles(12);
    test_drained("held_release");
  endtask

  task automatic test_wrap;
    int p0, r0;
    p0 = press_seen;
    r0 = release_seen;
    for (int i = 0; i < 16; i++) begin
      press_ch(2'b10);
      wait_cycles(10);
      release_ch(2'b10);
      wait_cycles(10);
    end
    test_drained("wrap");
    checks = checks + 1;
    if (press_seen - p0 != 16 || release_seen - r0 != 16) begin
      errors = errors + 1;
      $display("FAIL wrap_pulse_count got press=%0d release=%0d exp 16/16", press_seen - p0, release_seen - r0);
    end
    checks = checks + 1;
    if (press_count !== 8'h01) begin
      errors = errors + 1;
      $display("FAIL wrap_final_count got=%h exp=01", press_count);
    end
  endtask

  initial begin
    reset    = 1'b0;
    button_n = 2'b11;
    @(negedge clock);
    test_reset;
    test_clean_press;
    test_release;
    test_bounce;
    test_simultaneous;
    test_reset_mid;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
